// File: rtl/pixy_pid_xy.sv
// Two-axis pan/tilt PID for Pixy blob tracking: one shared multiplier, sequential per-axis evaluation.
// Define PIXY_PID_DERIV_EN to include the derivative term (DT state, prev_err storage).
module pixy_pid_xy #(
  parameter logic [15:0]        SETPOINT_X = 16'd158,
  parameter logic [15:0]        SETPOINT_Y = 16'd104,
  parameter logic signed [11:0] KP         = 12'sd40,
  parameter logic signed [11:0] KI         = 12'sd1,
  parameter logic signed [11:0] KD         = 12'sd80,
  parameter int unsigned        SHIFT      = 6,
  parameter int                 INT_LIM    = 4095,
  parameter int                 OUT_CENTER = 1500,
  parameter int                 OUT_MIN    = 1000,
  parameter int                 OUT_MAX    = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x_center_in,
  input  logic [15:0] y_center_in,
  input  logic        new_vals,
  output logic [15:0] x_cmd,
  output logic [15:0] y_cmd,
  output logic        cmd_valid
);

  typedef enum logic [2:0] {IDLE, ERR, PT, IT, DT, OUT, DONE} state_t;

  localparam logic signed [20:0] LIM_P     = 21'(INT_LIM);
  localparam logic signed [20:0] LIM_N     = -21'(INT_LIM);
  localparam logic signed [40:0] CENTER_W  = 41'(OUT_CENTER);
  localparam logic signed [40:0] MIN_W     = 41'(OUT_MIN);
  localparam logic signed [40:0] MAX_W     = 41'(OUT_MAX);
  localparam logic [15:0]        CENTER_16 = 16'(OUT_CENTER);
  localparam logic [15:0]        MIN_16    = 16'(OUT_MIN);
  localparam logic [15:0]        MAX_16    = 16'(OUT_MAX);

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               sync3_q, sync3_d;
  logic               pending_q, pending_d;
  logic [15:0]        x_cap_q, x_cap_d;
  logic [15:0]        y_cap_q, y_cap_d;
  logic               lost_q, lost_d;
  logic               axis_q, axis_d;
  logic signed [16:0] err_q, err_d;
  logic signed [19:0] integ_x_q, integ_x_d;
  logic signed [19:0] integ_y_q, integ_y_d;
  logic signed [39:0] acc_q, acc_d;
  logic [15:0]        x_axis_q, x_axis_d;
  logic [15:0]        x_cmd_q, x_cmd_d;
  logic [15:0]        y_cmd_q, y_cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
`ifdef PIXY_PID_DERIV_EN
  logic signed [17:0] deriv_q, deriv_d;
  logic signed [16:0] prev_x_q, prev_x_d;
  logic signed [16:0] prev_y_q, prev_y_d;
  logic signed [16:0] prev_cur;
  logic signed [17:0] deriv_new;
`endif

  logic               start_evt;
  logic [15:0]        cur_pos, cur_sp;
  logic signed [16:0] err_new;
  logic signed [19:0] integ_cur;
  logic signed [20:0] integ_sum;
  logic signed [19:0] integ_new;
  logic signed [11:0] mul_a;
  logic signed [19:0] mul_b;
  logic signed [31:0] mul_a_ext, mul_b_ext, prod;
  logic signed [39:0] prod_ext;
  logic signed [39:0] acc_sh;
  logic signed [40:0] cmd_sum;
  logic [15:0]        cmd_new;

  assign start_evt = sync2_q & ~sync3_q;

  // Error, derivative and clamped integrator for the axis currently selected.
  always_comb begin
    cur_pos   = axis_q ? y_cap_q : x_cap_q;
    cur_sp    = axis_q ? SETPOINT_Y : SETPOINT_X;
    err_new   = $signed({1'b0, cur_sp}) - $signed({1'b0, cur_pos});
    integ_cur = axis_q ? integ_y_q : integ_x_q;
    integ_sum = $signed({integ_cur[19], integ_cur}) + $signed({{4{err_new[16]}}, err_new});
    if (integ_sum > LIM_P) begin
      integ_new = LIM_P[19:0];
    end else if (integ_sum < LIM_N) begin
      integ_new = LIM_N[19:0];
    end else begin
      integ_new = integ_sum[19:0];
    end
`ifdef PIXY_PID_DERIV_EN
    prev_cur  = axis_q ? prev_y_q : prev_x_q;
    deriv_new = $signed({err_new[16], err_new}) - $signed({prev_cur[16], prev_cur});
`endif
  end

  always_comb begin
    mul_a = KP;
    mul_b = {{3{err_q[16]}}, err_q};
    case (state_q)
      IT: begin
        mul_a = KI;
        mul_b = integ_cur;
      end
      DT: begin
        mul_a = KD;
`ifdef PIXY_PID_DERIV_EN
        mul_b = {{2{deriv_q[17]}}, deriv_q};
`else
        mul_b = '0;
`endif
      end
      default: ;
    endcase
    mul_a_ext = {{20{mul_a[11]}}, mul_a};
    mul_b_ext = {{12{mul_b[19]}}, mul_b};
    prod      = mul_a_ext * mul_b_ext;
    prod_ext  = {{8{prod[31]}}, prod};
  end

  always_comb begin
    acc_sh  = acc_q >>> SHIFT;
    cmd_sum = $signed({acc_sh[39], acc_sh}) + CENTER_W;
    if (lost_q) begin
      cmd_new = CENTER_16;
    end else if (cmd_sum > MAX_W) begin
      cmd_new = MAX_16;
    end else if (cmd_sum < MIN_W) begin
      cmd_new = MIN_16;
    end else begin
      cmd_new = cmd_sum[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = new_vals;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    pending_d   = pending_q;
    x_cap_d     = x_cap_q;
    y_cap_d     = y_cap_q;
    lost_d      = lost_q;
    axis_d      = axis_q;
    err_d       = err_q;
    integ_x_d   = integ_x_q;
    integ_y_d   = integ_y_q;
    acc_d       = acc_q;
    x_axis_d    = x_axis_q;
    x_cmd_d     = x_cmd_q;
    y_cmd_d     = y_cmd_q;
    cmd_valid_d = 1'b0;
`ifdef PIXY_PID_DERIV_EN
    deriv_d     = deriv_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
`endif

    if (start_evt && state_q != IDLE) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_evt || pending_q) begin
          x_cap_d   = x_center_in;
          y_cap_d   = y_center_in;
          lost_d    = (x_center_in == '0) && (y_center_in == '0);
          axis_d    = 1'b0;
          pending_d = 1'b0;
          state_d   = ERR;
        end
      end
      ERR: begin
        acc_d = '0;
        err_d = lost_q ? '0 : err_new;
        if (axis_q) begin
          integ_y_d = lost_q ? '0 : integ_new;
        end else begin
          integ_x_d = lost_q ? '0 : integ_new;
        end
`ifdef PIXY_PID_DERIV_EN
        deriv_d = lost_q ? '0 : deriv_new;
        if (axis_q) begin
          prev_y_d = lost_q ? '0 : err_new;
        end else begin
          prev_x_d = lost_q ? '0 : err_new;
        end
`endif
        state_d = PT;
      end
      PT: begin
        acc_d   = acc_q + prod_ext;
        state_d = IT;
      end
      IT: begin
        acc_d = acc_q + prod_ext;
`ifdef PIXY_PID_DERIV_EN
        state_d = DT;
`else
        state_d = OUT;
`endif
      end
      DT: begin
        acc_d   = acc_q + prod_ext;
        state_d = OUT;
      end
      OUT: begin
        // X result is parked so both commands appear together with the strobe.
        if (!axis_q) begin
          x_axis_d = cmd_new;
          axis_d   = 1'b1;
          state_d  = ERR;
        end else begin
          x_cmd_d     = x_axis_q;
          y_cmd_d     = cmd_new;
          cmd_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      pending_q   <= 1'b0;
      x_cap_q     <= '0;
      y_cap_q     <= '0;
      lost_q      <= 1'b0;
      axis_q      <= 1'b0;
      err_q       <= '0;
      integ_x_q   <= '0;
      integ_y_q   <= '0;
      acc_q       <= '0;
      x_axis_q    <= CENTER_16;
      x_cmd_q     <= CENTER_16;
      y_cmd_q     <= CENTER_16;
      cmd_valid_q <= 1'b0;
`ifdef PIXY_PID_DERIV_EN
      deriv_q     <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      pending_q   <= pending_d;
      x_cap_q     <= x_cap_d;
      y_cap_q     <= y_cap_d;
      lost_q      <= lost_d;
      axis_q      <= axis_d;
      err_q       <= err_d;
      integ_x_q   <= integ_x_d;
      integ_y_q   <= integ_y_d;
      acc_q       <= acc_d;
      x_axis_q    <= x_axis_d;
      x_cmd_q     <= x_cmd_d;
      y_cmd_q     <= y_cmd_d;
      cmd_valid_q <= cmd_valid_d;
`ifdef PIXY_PID_DERIV_EN
      deriv_q     <= deriv_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
`endif
    end
  end

  assign x_cmd     = x_cmd_q;
  assign y_cmd     = y_cmd_q;
  assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_pixy_pid_xy.sv
// Randomized bench for pixy_pid_xy: default-gain and KP=400 instances checked against a PID model.
module tb_pixy_pid_xy;

`ifdef PIXY_PID_DERIV_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x_center_in, y_center_in;
  logic        new_vals;
  logic [15:0] x_cmd0, y_cmd0, x_cmd1, y_cmd1;
  logic        cmd_valid0, cmd_valid1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int vq[$];
  int xq[$], yq[$], kxq[$], kyq[$], kvq[$];

  int m_integ[2][2];
  int m_prev[2][2];
  int ex[2], ey[2];

  pixy_pid_xy dut (
    .clk(clk), .reset(reset), .x_center_in(x_center_in), .y_center_in(y_center_in),
    .new_vals(new_vals), .x_cmd(x_cmd0), .y_cmd(y_cmd0), .cmd_valid(cmd_valid0)
  );

  pixy_pid_xy #(.KP(12'sd400)) dut_kp (
    .clk(clk), .reset(reset), .x_center_in(x_center_in), .y_center_in(y_center_in),
    .new_vals(new_vals), .x_cmd(x_cmd1), .y_cmd(y_cmd1), .cmd_valid(cmd_valid1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (cmd_valid0) begin
      vq.push_back(cyc);
      xq.push_back(int'(x_cmd0));
      yq.push_back(int'(y_cmd0));
      kxq.push_back(int'(x_cmd1));
      kyq.push_back(int'(y_cmd1));
      kvq.push_back(int'(cmd_valid1));
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_axis(input int inst, input int ax, input int sp, input int c);
    int     err, deriv, kp, cmd;
    longint acc, sh;
    kp    = (inst == 0) ? 40 : 400;
    err   = sp - c;
    deriv = err - m_prev[inst][ax];
    m_integ[inst][ax] = m_integ[inst][ax] + err;
    if (m_integ[inst][ax] > 4095)  m_integ[inst][ax] = 4095;
    if (m_integ[inst][ax] < -4095) m_integ[inst][ax] = -4095;
    m_prev[inst][ax] = err;
    acc = longint'(kp) * err + longint'(m_integ[inst][ax]);
`ifdef PIXY_PID_DERIV_EN
    acc = acc + 80 * longint'(deriv);
`else
    if (deriv == 0) acc = acc + 0;
`endif
    sh  = acc >>> 6;
    cmd = int'(sh) + 1500;
    if (cmd > 2000) cmd = 2000;
    if (cmd < 1000) cmd = 1000;
    return cmd;
  endfunction

  task automatic model_frame(input int x, input int y);
    for (int i = 0; i < 2; i++) begin
      if (x == 0 && y == 0) begin
        for (int a = 0; a < 2; a++) begin
          m_integ[i][a] = 0;
          m_prev[i][a]  = 0;
        end
        ex[i] = 1500;
        ey[i] = 1500;
      end else begin
        ex[i] = model_axis(i, 0, 158, x);
        ey[i] = model_axis(i, 1, 104, y);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 2; a++) begin
        m_integ[i][a] = 0;
        m_prev[i][a]  = 0;
      end
  endtask

  task automatic clear_q();
    vq.delete(); xq.delete(); yq.delete(); kxq.delete(); kyq.delete(); kvq.delete();
  endtask

  task automatic check_strobe(input int k, input int exp_cyc, input int e0x, input int e0y,
                              input int e1x, input int e1y);
    check("latency", vq[k], exp_cyc);
    check("x_cmd", xq[k], e0x);
    check("y_cmd", yq[k], e0y);
    check("kp_valid", kvq[k], 1);
    check("kp_x_cmd", kxq[k], e1x);
    check("kp_y_cmd", kyq[k], e1y);
  endtask

  task automatic do_frame(input int x, input int y);
    int t0;
    model_frame(x, y);
    clear_q();
    x_center_in = 16'(x);
    y_center_in = 16'(y);
    t0 = cyc;
    new_vals = 1'b1;
    for (int i = 0; i < 40 && vq.size() == 0; i++) @(negedge clk);
    if (vq.size() == 0) begin
      check("frame_timeout", 0, 1);
    end else begin
      check_strobe(0, t0 + 2 + LAT, ex[0], ey[0], ex[1], ey[1]);
    end
    new_vals = 1'b0;
    repeat (6) @(negedge clk);
    check("strobe_count", vq.size(), 1);
  endtask

  initial begin
    int t0, r, px, py;
    int e1[4];
    reset = 1'b1;
    new_vals = 1'b0;
    x_center_in = '0;
    y_center_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x_cmd", x_cmd0, 1500);
    check("rst_y_cmd", y_cmd0, 1500);
    check("rst_valid", cmd_valid0, 0);
    reset = 1'b0;
    @(negedge clk);

    do_frame(158, 104);
    do_frame(198, 104);
    do_frame(5, 104);
    for (int i = 0; i < 14; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        px = 0; py = 0;
      end else if (r == 1) begin
        px = 65535; py = int'($urandom_range(0, 65535));
      end else begin
        px = int'($urandom_range(0, 319)); py = int'($urandom_range(0, 199));
      end
      do_frame(px, py);
    end

    do_frame(20, 180);
    do_frame(0, 0);
    do_frame(158, 104);

    // Extra edges while busy: one is queued, later ones are absorbed.
    model_frame(170, 90);
    e1[0] = ex[0]; e1[1] = ey[0]; e1[2] = ex[1]; e1[3] = ey[1];
    model_frame(170, 90);
    clear_q();
    x_center_in = 16'd170;
    y_center_in = 16'd90;
    t0 = cyc;
    new_vals = 1'b1;
    repeat (2) @(negedge clk); new_vals = 1'b0;
    repeat (2) @(negedge clk); new_vals = 1'b1;
    repeat (2) @(negedge clk); new_vals = 1'b0;
    repeat (2) @(negedge clk); new_vals = 1'b1;
    for (int i = 0; i < 60 && vq.size() < 2; i++) @(negedge clk);
    if (vq.size() < 2) begin
      check("pending_timeout", vq.size(), 2);
    end else begin
      check_strobe(0, t0 + 2 + LAT, e1[0], e1[1], e1[2], e1[3]);
      check_strobe(1, t0 + 2 + 2 * LAT + 1, ex[0], ey[0], ex[1], ey[1]);
    end
    new_vals = 1'b0;
    repeat (30) @(negedge clk);
    check("pending_count", vq.size(), 2);

    // Abort mid-computation with reset.
    clear_q();
    x_center_in = 16'd120;
    y_center_in = 16'd60;
    new_vals = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    new_vals = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_rst_x", x_cmd0, 1500);
    check("abort_rst_y", y_cmd0, 1500);
    check("abort_rst_valid", cmd_valid0, 0);
    reset = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    check("abort_no_strobe", vq.size(), 0);
    check("abort_x_cmd", x_cmd0, 1500);
    check("abort_kp_y_cmd", y_cmd1, 1500);
    do_frame(120, 60);
    do_frame(300, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

endmodule
